// File: rtl/cache_txn_id_tracker.sv
// ----------------------------------------------------------------------------
// cache_txn_id_tracker
//
// Transaction-ID allocator/tracker sitting between the cache request path and
// the memory response path. It consumes an external, pre-initialized free-list
// FIFO. Each request handshake pops the free-list head, hands that ID to the
// requester and records per-ID metadata. A response for a pending ID yields a
// registered completion carrying the stored metadata. The ID is returned to
// the free list when the completion is accepted.
//
// Optional feature (compile-time macro ID_TRACKER_HWM_EN):
//   adds hwm_o, the highest outstanding count seen since reset/flush.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   flush_i                drop every tracked transaction (free list flushes too)
//   req_valid_i/ready_o    allocation handshake; req_meta_i stored,
//                          req_id_o returned (combinational)
//   fl_empty_i, fl_id_i    free-list status / head
//   fl_pop_o               pop free-list head
//   fl_push_o, fl_id_o     return an ID to the free list
//   rsp_valid_i/ready_o    response handshake, rsp_id_i selects the entry
//   cpl_valid_o/ready_i    registered completion handshake
//   cpl_id_o, cpl_meta_o   completion payload
//   spurious_o             one-cycle pulse: response for a non-pending ID
//   outstanding_o, idle_o  allocated-but-not-freed count, count == 0
//   hwm_o                  (ID_TRACKER_HWM_EN only) outstanding high-water mark
// ----------------------------------------------------------------------------
module cache_txn_id_tracker #(
    parameter int NUM_IDS    = 8,
    parameter int ID_WIDTH   = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1,
    parameter int META_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [META_WIDTH-1:0] req_meta_i,
    output logic [ID_WIDTH-1:0]   req_id_o,
    input  logic                  fl_empty_i,
    input  logic [ID_WIDTH-1:0]   fl_id_i,
    output logic                  fl_pop_o,
    output logic                  fl_push_o,
    output logic [ID_WIDTH-1:0]   fl_id_o,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    input  logic [ID_WIDTH-1:0]   rsp_id_i,
    output logic                  cpl_valid_o,
    input  logic                  cpl_ready_i,
    output logic [ID_WIDTH-1:0]   cpl_id_o,
    output logic [META_WIDTH-1:0] cpl_meta_o,
    output logic                  spurious_o,
    output logic [ID_WIDTH:0]     outstanding_o,
    output logic                  idle_o
`ifdef ID_TRACKER_HWM_EN
    ,
    output logic [ID_WIDTH:0]     hwm_o
`endif
);

    localparam logic [ID_WIDTH:0] MAX_CNT = (ID_WIDTH+1)'(NUM_IDS);

    logic [NUM_IDS-1:0]                 valid_q, valid_d;
    logic [NUM_IDS-1:0][META_WIDTH-1:0] meta_q;
    logic                               cpl_valid_q, cpl_valid_d;
    logic [ID_WIDTH-1:0]                cpl_id_q, cpl_id_d;
    logic [META_WIDTH-1:0]              cpl_meta_q, cpl_meta_d;
    logic                               spurious_q, spurious_d;
    logic [ID_WIDTH:0]                  cnt_q, cnt_d;

    logic alloc, rsp_hs, rsp_pend, free;

    // Allocation: zero-latency pass-through of the free-list head.
    assign req_ready_o = ~fl_empty_i & ~flush_i;
    assign req_id_o    = fl_id_i;
    assign alloc       = req_valid_i & req_ready_o;
    assign fl_pop_o    = alloc;

    // Response is accepted only when the completion register can take it.
    assign rsp_ready_o = (~cpl_valid_q | cpl_ready_i) & ~flush_i;
    assign rsp_hs      = rsp_valid_i & rsp_ready_o;
    // Uses the registered valid bit, so an ID allocated this same cycle
    // is still seen as non-pending.
    assign rsp_pend    = valid_q[rsp_id_i];

    // Free on completion acceptance; a flushed completion is dropped.
    assign free      = cpl_valid_q & cpl_ready_i & ~flush_i;
    assign fl_push_o = free;
    assign fl_id_o   = cpl_id_q;

    assign cpl_valid_o   = cpl_valid_q;
    assign cpl_id_o      = cpl_id_q;
    assign cpl_meta_o    = cpl_meta_q;
    assign spurious_o    = spurious_q;
    assign outstanding_o = cnt_q;
    assign idle_o        = (cnt_q == '0);

    always_comb begin
        valid_d = valid_q;
        if (alloc)               valid_d[fl_id_i]  = 1'b1;
        if (rsp_hs && rsp_pend)  valid_d[rsp_id_i] = 1'b0;
        if (flush_i)             valid_d           = '0;
    end

    always_comb begin
        cpl_valid_d = cpl_valid_q & ~cpl_ready_i;
        cpl_id_d    = cpl_id_q;
        cpl_meta_d  = cpl_meta_q;
        if (rsp_hs && rsp_pend) begin
            cpl_valid_d = 1'b1;
            cpl_id_d    = rsp_id_i;
            cpl_meta_d  = meta_q[rsp_id_i];
        end
        if (flush_i) cpl_valid_d = 1'b0;
    end

    assign spurious_d = rsp_hs & ~rsp_pend & ~flush_i;

    // Saturating up/down counter; simultaneous alloc+free cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (alloc && !free && cnt_q != MAX_CNT)  cnt_d = cnt_q + 1'b1;
        if (free && !alloc && cnt_q != '0)       cnt_d = cnt_q - 1'b1;
        if (flush_i)                             cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            cpl_valid_q <= 1'b0;
            cpl_id_q    <= '0;
            cpl_meta_q  <= '0;
            spurious_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_id_q    <= cpl_id_d;
            cpl_meta_q  <= cpl_meta_d;
            spurious_q  <= spurious_d;
            cnt_q       <= cnt_d;
        end
    end

    // Metadata table is deliberately not reset; valid_q qualifies it.
    always_ff @(posedge clk_i) begin
        if (alloc) meta_q[fl_id_i] <= req_meta_i;
    end

`ifdef ID_TRACKER_HWM_EN
    logic [ID_WIDTH:0] hwm_q, hwm_d;

    // Tracks the registered count, so it trails outstanding_o by one cycle.
    always_comb begin
        hwm_d = (cnt_q > hwm_q) ? cnt_q : hwm_q;
        if (flush_i) hwm_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) hwm_q <= '0;
        else       hwm_q <= hwm_d;
    end

    assign hwm_o = hwm_q;
`else
    // No high-water tracking in this build.
`endif

`ifndef SYNTHESIS
    // Allocating an ID that is still pending means the free list is corrupt.
    always @(posedge clk_i) begin
        if (!rst_i && alloc)
            assert (!valid_q[fl_id_i])
            else $error("cache_txn_id_tracker: allocating pending ID %0d", fl_id_i);
    end
`endif

endmodule

// File: tb/tb_cache_txn_id_tracker.sv
`timescale 1ns/1ps
module tb_cache_txn_id_tracker;

    logic        clk, rst, flush;
    logic        req_valid, req_ready;
    logic [15:0] req_meta;
    logic [2:0]  req_id;
    logic        fl_empty;
    logic [2:0]  fl_id_in;
    logic        fl_pop, fl_push;
    logic [2:0]  fl_id_out;
    logic        rsp_valid, rsp_ready;
    logic [2:0]  rsp_id;
    logic        cpl_valid, cpl_ready;
    logic [2:0]  cpl_id;
    logic [15:0] cpl_meta;
    logic        spurious;
    logic [3:0]  outstanding;
    logic        idle;
`ifdef ID_TRACKER_HWM_EN
    logic [3:0]  hwm;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    cache_txn_id_tracker dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_meta_i(req_meta), .req_id_o(req_id),
        .fl_empty_i(fl_empty), .fl_id_i(fl_id_in),
        .fl_pop_o(fl_pop), .fl_push_o(fl_push), .fl_id_o(fl_id_out),
        .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_id_i(rsp_id),
        .cpl_valid_o(cpl_valid), .cpl_ready_i(cpl_ready),
        .cpl_id_o(cpl_id), .cpl_meta_o(cpl_meta),
        .spurious_o(spurious), .outstanding_o(outstanding), .idle_o(idle)
`ifdef ID_TRACKER_HWM_EN
        , .hwm_o(hwm)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-list FIFO model: initialized with 0..7, reinitialized on flush.
    logic [2:0] fl_mem [8];
    logic [2:0] fl_rd, fl_wr;
    logic [3:0] fl_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            for (int i = 0; i < 8; i++) fl_mem[i] <= 3'(i);
            fl_rd  <= '0;
            fl_wr  <= '0;
            fl_cnt <= 4'd8;
        end else begin
            if (fl_pop)  fl_rd <= fl_rd + 3'd1;
            if (fl_push) begin
                fl_mem[fl_wr] <= fl_id_out;
                fl_wr         <= fl_wr + 3'd1;
            end
            fl_cnt <= fl_cnt - {3'd0, fl_pop} + {3'd0, fl_push};
        end
    end

    assign fl_empty = (fl_cnt == 4'd0);
    assign fl_id_in = fl_mem[fl_rd];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        req_valid = 1'b0; req_meta = '0;
        rsp_valid = 1'b0; rsp_id = '0; cpl_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // Reset state
        chk("rst_cpl_valid", cpl_valid, 0);
        chk("rst_spurious", spurious, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_idle", idle, 1);
        chk("rst_req_ready", req_ready, 1);

        // 1: eight back-to-back allocations
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_meta  = 16'h100 + 16'(i);
            #1;
            chk("alloc_id", req_id, i);
            chk("alloc_pop", fl_pop, 1);
            tick();
        end
        req_valid = 1'b0;
        #1;
        chk("full_req_ready", req_ready, 0);
        chk("full_outstanding", outstanding, 8);
        chk("full_idle", idle, 0);

        // 2: response ID 3, completion consumed immediately
        rsp_valid = 1'b1; rsp_id = 3'd3; cpl_ready = 1'b1;
        #1 chk("t2_rsp_ready", rsp_ready, 1);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t2_cpl_valid", cpl_valid, 1);
        chk("t2_cpl_id", cpl_id, 3);
        chk("t2_cpl_meta", cpl_meta, 16'h103);
        chk("t2_push", fl_push, 1);
        chk("t2_fl_id", fl_id_out, 3);
        tick();
        chk("t2_outstanding", outstanding, 7);
        chk("t2_cpl_done", cpl_valid, 0);
        chk("t2_req_id_recycled", req_id, 3);

        // 3: completion back-pressure with responses for IDs 1 and 2
        cpl_ready = 1'b0; rsp_valid = 1'b1; rsp_id = 3'd1;
        #1 chk("t3_rsp1_ready", rsp_ready, 1);
        tick();
        rsp_id = 3'd2;
        #1;
        chk("t3_cpl1_valid", cpl_valid, 1);
        chk("t3_cpl1_id", cpl_id, 1);
        chk("t3_cpl1_meta", cpl_meta, 16'h101);
        chk("t3_rsp2_blocked", rsp_ready, 0);
        chk("t3_no_push", fl_push, 0);
        tick();
        chk("t3_cpl1_held", cpl_id, 1);
        chk("t3_rsp2_still_blocked", rsp_ready, 0);
        cpl_ready = 1'b1;
        #1;
        chk("t3_rsp2_ready", rsp_ready, 1);
        chk("t3_push1", fl_push, 1);
        chk("t3_push1_id", fl_id_out, 1);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t3_cpl2_valid", cpl_valid, 1);
        chk("t3_cpl2_id", cpl_id, 2);
        chk("t3_cpl2_meta", cpl_meta, 16'h102);
        chk("t3_outstanding6", outstanding, 6);
        tick();
        chk("t3_cpl2_done", cpl_valid, 0);
        chk("t3_outstanding5", outstanding, 5);

        // 4: response for a non-pending ID (3 was freed)
        rsp_valid = 1'b1; rsp_id = 3'd3;
        #1 chk("t4_rsp_ready", rsp_ready, 1);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t4_spurious", spurious, 1);
        chk("t4_no_cpl", cpl_valid, 0);
        chk("t4_no_push", fl_push, 0);
        tick();
        chk("t4_spurious_pulse", spurious, 0);
        chk("t4_outstanding", outstanding, 5);

        // 5: alloc + response + free in one cycle
        cpl_ready = 1'b0; rsp_valid = 1'b1; rsp_id = 3'd0;
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t5_cpl0_id", cpl_id, 0);
        chk("t5_cpl0_meta", cpl_meta, 16'h100);
        req_valid = 1'b1; req_meta = 16'h2AA;
        cpl_ready = 1'b1; rsp_valid = 1'b1; rsp_id = 3'd4;
        #1;
        chk("t5_req_id", req_id, 3);
        chk("t5_pop", fl_pop, 1);
        chk("t5_push", fl_push, 1);
        chk("t5_push_id", fl_id_out, 0);
        chk("t5_rsp_ready", rsp_ready, 1);
        tick();
        req_valid = 1'b0; rsp_valid = 1'b0;
        #1;
        chk("t5_outstanding_same", outstanding, 5);
        chk("t5_cpl4_id", cpl_id, 4);
        chk("t5_cpl4_meta", cpl_meta, 16'h104);
        tick();
        chk("t5_outstanding4", outstanding, 4);

        // 6: flush with 4 outstanding and a held completion (ID 3, new meta)
        cpl_ready = 1'b0; rsp_valid = 1'b1; rsp_id = 3'd3;
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t6_cpl3_valid", cpl_valid, 1);
        chk("t6_cpl3_meta", cpl_meta, 16'h2AA);
        chk("t6_outstanding4", outstanding, 4);
`ifdef ID_TRACKER_HWM_EN
        // Peak so far was 8 (after the eight allocations).
        chk("t6_hwm_before", hwm, 8);
`endif
        flush = 1'b1; cpl_ready = 1'b1; req_valid = 1'b1; rsp_valid = 1'b1; rsp_id = 3'd5;
        #1;
        chk("t6_flush_no_push", fl_push, 0);
        chk("t6_flush_no_pop", fl_pop, 0);
        chk("t6_flush_req_ready", req_ready, 0);
        chk("t6_flush_rsp_ready", rsp_ready, 0);
        tick();
        flush = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0;
        #1;
        chk("t6_outstanding0", outstanding, 0);
        chk("t6_cpl_dropped", cpl_valid, 0);
        chk("t6_idle", idle, 1);
        chk("t6_no_push_after", fl_push, 0);
        chk("t6_fl_reinit", req_id, 0);
        chk("t6_no_spurious", spurious, 0);
`ifdef ID_TRACKER_HWM_EN
        chk("t6_hwm_after", hwm, 0);
`endif

        // 7: response in the same cycle as allocation of that ID is non-pending
        req_valid = 1'b1; req_meta = 16'h0055; rsp_valid = 1'b1; rsp_id = 3'd0;
        #1;
        chk("t7_req_id", req_id, 0);
        chk("t7_rsp_ready", rsp_ready, 1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t7_spurious", spurious, 1);
        chk("t7_no_cpl", cpl_valid, 0);
        chk("t7_outstanding1", outstanding, 1);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t7_cpl_valid", cpl_valid, 1);
        chk("t7_cpl_id", cpl_id, 0);
        chk("t7_cpl_meta", cpl_meta, 16'h0055);
        chk("t7_spurious_clear", spurious, 0);
        tick();
        chk("t7_outstanding0", outstanding, 0);
        chk("t7_idle", idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
